// File: rtl/johnson_code_monitor.sv
// Johnson (twisted-ring) code monitor: decodes a sampled code to index/one-hot, checks legality
// and single-step sequencing, tracks sync and counts wraps. Macro JCM_AUTO_RESYNC_EN enables
// automatic exit from FAULT after 2*WIDTH consecutive good steps.
module johnson_code_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IDX_W = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     jc_in_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic [2*WIDTH-1:0]   onehot_o,
  output logic                 code_valid_o,
  output logic                 synced_o,
  output logic                 fault_o,
  output logic                 step_err_o,
  output logic [CNT_W-1:0]     wrap_cnt_o
);

  localparam int unsigned NSt = 2 * WIDTH;

  typedef enum logic [1:0] {StSeek, StTrack, StFault} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q, prev_q;
  logic [NSt-1:0]     onehot_q;
  logic               code_valid_q, synced_q, fault_q, step_err_q;
  logic [CNT_W-1:0]   wrap_q;

`ifdef JCM_AUTO_RESYNC_EN
  localparam int unsigned GoodW = $clog2(NSt + 1);
  logic [GoodW-1:0]   good_q;
  logic               arm_q;  // set after an illegal code: next legal sample only reloads prev
`endif

  logic               legal;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   prev_nxt;
  logic               step_ok;
  logic               wrap_hit;

  always_comb begin
    int unsigned trans;
    int unsigned ones;
    trans = 0;
    ones  = 0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (jc_in_i[i] != jc_in_i[i+1]) trans++;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (jc_in_i[i]) ones++;
    end
    legal = (trans <= 1);
    if (jc_in_i[WIDTH-1]) idx = IDX_W'(WIDTH + (WIDTH - ones));
    else                  idx = IDX_W'(ones);
  end

  always_comb begin
    prev_nxt = (prev_q == IDX_W'(NSt - 1)) ? '0 : prev_q + 1'b1;
    step_ok  = legal && ((idx == prev_q) || (idx == prev_nxt));
    wrap_hit = (prev_q == IDX_W'(NSt - 1)) && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StSeek;
      idx_q        <= '0;
      prev_q       <= '0;
      onehot_q     <= '0;
      code_valid_q <= 1'b0;
      synced_q     <= 1'b0;
      fault_q      <= 1'b0;
      step_err_q   <= 1'b0;
      wrap_q       <= '0;
`ifdef JCM_AUTO_RESYNC_EN
      good_q       <= '0;
      arm_q        <= 1'b0;
`endif
    end else begin
      step_err_q <= 1'b0;
      if (en_i) begin
        code_valid_q <= legal;
        if (legal) begin
          idx_q    <= idx;
          onehot_q <= NSt'(1) << idx;
        end else begin
          onehot_q <= '0;
        end

        unique case (state_q)
          StSeek: begin
            if (legal) begin
              state_q  <= StTrack;
              synced_q <= 1'b1;
              prev_q   <= idx;
            end
          end
          StTrack: begin
            if (step_ok) begin
              prev_q <= idx;
              if (wrap_hit) wrap_q <= wrap_q + 1'b1;
            end else begin
              state_q    <= StFault;
              synced_q   <= 1'b0;
              fault_q    <= 1'b1;
              step_err_q <= 1'b1;
              if (legal) prev_q <= idx;
`ifdef JCM_AUTO_RESYNC_EN
              good_q <= '0;
              arm_q  <= ~legal;
`endif
            end
          end
          StFault: begin
            if (legal) prev_q <= idx;
`ifdef JCM_AUTO_RESYNC_EN
            if (!legal) begin
              good_q <= '0;
              arm_q  <= 1'b1;
            end else if (arm_q || !step_ok) begin
              good_q <= '0;
              arm_q  <= 1'b0;
            end else if (good_q == GoodW'(NSt - 1)) begin
              good_q   <= '0;
              state_q  <= StTrack;
              synced_q <= 1'b1;
              fault_q  <= 1'b0;
            end else begin
              good_q <= good_q + 1'b1;
            end
`endif
          end
          default: state_q <= StSeek;
        endcase
      end
    end
  end

  assign idx_o        = idx_q;
  assign onehot_o     = onehot_q;
  assign code_valid_o = code_valid_q;
  assign synced_o     = synced_q;
  assign fault_o      = fault_q;
  assign step_err_o   = step_err_q;
  assign wrap_cnt_o   = wrap_q;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Directed bench for johnson_code_monitor (WIDTH=4); expectations follow JCM_AUTO_RESYNC_EN.
module tb_johnson_code_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic [3:0] jc_in_i;
  logic [2:0] idx_o;
  logic [7:0] onehot_o;
  logic       code_valid_o, synced_o, fault_o, step_err_o;
  logic [7:0] wrap_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_code_monitor #(.WIDTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_i),
    .jc_in_i      (jc_in_i),
    .idx_o        (idx_o),
    .onehot_o     (onehot_o),
    .code_valid_o (code_valid_o),
    .synced_o     (synced_o),
    .fault_o      (fault_o),
    .step_err_o   (step_err_o),
    .wrap_cnt_o   (wrap_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [3:0] c);
    reset   = r;
    en_i    = e;
    jc_in_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] idx, input logic [7:0] oh,
                         input logic cv, input logic sy, input logic fl, input logic se);
    chk({tag, ".idx"}, 32'(idx_o), 32'(idx));
    chk({tag, ".onehot"}, 32'(onehot_o), 32'(oh));
    chk({tag, ".valid"}, 32'(code_valid_o), 32'(cv));
    chk({tag, ".synced"}, 32'(synced_o), 32'(sy));
    chk({tag, ".fault"}, 32'(fault_o), 32'(fl));
    chk({tag, ".step_err"}, 32'(step_err_o), 32'(se));
  endtask

  initial begin
    // 1: reset then a full clean cycle with one wrap
    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0000);
    chk_all("rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.wrap", 32'(wrap_cnt_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, codes[i]);
      chk_all($sformatf("seq%0d", i), 3'(i), 8'(8'h01 << i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("seq.wrap_before", 32'(wrap_cnt_o), 32'd0);
    step(1'b0, 1'b1, 4'b0000);
    chk_all("seq_wrap", 3'd0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("seq.wrap_after", 32'(wrap_cnt_o), 32'd1);

    // 2: hold at index 2 with en toggling
    step(1'b0, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b0011);
    chk_all("hold_a", 3'd2, 8'b0000_0100, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0011);
    chk_all("hold_b", 3'd2, 8'b0000_0100, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0011);
    chk_all("hold_c", 3'd2, 8'b0000_0100, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: illegal code while tracking
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0001);
    chk_all("ill_pre", 3'd1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0101);
    chk_all("ill", 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0101);
    chk("ill.pulse_end", 32'(step_err_o), 32'd0);
    chk("ill.fault_hold", 32'(fault_o), 32'd1);

    // 4: skipped index, then 8 clean steps
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b0111);
    chk_all("skip", 3'd3, 8'h08, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, codes[(3 + k) % 8]);
      chk_all($sformatf("rs%0d", k), 3'((3 + k) % 8), 8'(8'h01 << ((3 + k) % 8)),
              1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 4'b0111);
`ifdef JCM_AUTO_RESYNC_EN
    chk_all("rs8", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    chk_all("rs8", 3'd3, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // 5: illegal codes in SEEK are ignored
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0110);
    chk_all("seek_a", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010);
    chk_all("seek_b", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100);
    chk_all("seek_c", 3'd6, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);

    // 6: three wraps, reset mid-sequence with en=1, resync at 1000
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    for (int w = 0; w < 3; w++) begin
      for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, codes[k % 8]);
    end
    step(1'b0, 1'b1, 4'b0001);
    chk("wrap3", 32'(wrap_cnt_o), 32'd3);
    step(1'b1, 1'b1, 4'b0011);
    chk_all("mid_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst.wrap", 32'(wrap_cnt_o), 32'd0);
    step(1'b0, 1'b1, 4'b1000);
    chk_all("resync", 3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("resync.wrap", 32'(wrap_cnt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_code_monitor.md
Name: johnson_code_monitor

Overview:
- Receive-side counterpart of the Johnson (twisted-ring) counter. Samples a WIDTH-bit Johnson code bus and decodes it to a binary index and a one-hot vector.
- Checks each sample for code legality and for legal sequencing: the code must hold or advance exactly one step.
- Tracks sync state and counts full-cycle wraps.
- Sits on the consumer side of any Johnson-counted sequencer or phase generator.

Parameters:
- WIDTH, 4, Johnson register width; code space is 2*WIDTH states; minimum 2.
- CNT_W, 8, width of the wrap counter.
- IDX_W (localparam), $clog2(2*WIDTH), index width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  sample strobe; jc_in is sampled at a rising clk edge only when en=1.
- jc_in  input  WIDTH  Johnson code under observation.
- idx_out  output  IDX_W  decoded state index.
- onehot_out  output  2*WIDTH  one-hot of idx_out; all zero when the last sample was illegal.
- code_valid  output  1  last sample was a legal Johnson code.
- synced  output  1  FSM is in TRACK.
- fault  output  1  FSM is in FAULT.
- step_err  output  1  one-cycle pulse on an illegal code or illegal step detected in TRACK.
- wrap_cnt  output  CNT_W  number of 2*WIDTH-1 -> 0 transitions; wraps modulo 2^CNT_W.

Behaviour:
- Legality:
  - Count the positions i in 0..WIDTH-2 where jc_in[i] != jc_in[i+1].
  - The code is legal iff that count is <= 1. This gives exactly 2*WIDTH legal codes.
- Index:
  - If jc_in[WIDTH-1]=0: idx = popcount(jc_in).
  - Otherwise: idx = WIDTH + number of zeros in jc_in.
  - For WIDTH=4 the sequence 0000,0001,0011,0111,1111,1110,1100,1000 decodes to 0..7.
- Timing:
  - All outputs are registered; latency is 1 cycle from the sampling edge.
  - With en=0, all outputs hold and step_err=0.
- Illegal sample: idx_out holds its previous value, onehot_out=0, code_valid=0.
- Reset:
  - Reset has priority over en.
  - Next cycle: idx_out=0, onehot_out=0, code_valid=0, synced=0, fault=0, step_err=0, wrap_cnt=0, state=SEEK, internal prev_idx=0.
- FSM SEEK:
  - en & legal -> TRACK; prev_idx := idx.
  - en & illegal -> stay in SEEK; no step_err, no fault.
- FSM TRACK:
  - en & legal & (idx==prev_idx or idx==(prev_idx+1) mod 2*WIDTH) -> stay in TRACK; prev_idx := idx.
  - If additionally prev_idx==2*WIDTH-1 and idx==0, wrap_cnt += 1.
  - en & (illegal or any other idx) -> FAULT; step_err=1 for one cycle; wrap_cnt unchanged.
- FSM FAULT:
  - Decode outputs continue to update; synced=0, fault=1.
  - A legal sample updates prev_idx; no further step_err pulses while in FAULT.
  - Exit is governed by the Optional Feature.
- Simultaneous events: a legal hold (same idx) is never an error; a wrap and a state change cannot coincide.

Optional Feature:
- Macro: JCM_AUTO_RESYNC_EN.
- Defined:
  - FAULT keeps a good-step counter.
  - The counter increments on each en sample that is legal and is a legal hold/advance relative to prev_idx.
  - It clears on any illegal code or bad step.
  - The first legal sample after an illegal one only loads prev_idx and counts 0.
  - When the counter reaches 2*WIDTH, go to TRACK: synced=1, fault=0.
- Undefined: FAULT is sticky until reset.

Test Plan:
1. WIDTH=4; reset 2 cycles; en=1; drive 0000,0001,0011,0111,1111,1110,1100,1000,0000 -> idx_out 0..7 then 0, one cycle late; synced=1 from the first sample; wrap_cnt=1 after the final 0000; fault=0, step_err never 1.
2. In TRACK, drive 0011 for 3 cycles with en toggling 1,0,1 -> idx_out=2 throughout, onehot_out=0000_0100, no step_err.
3. In TRACK at 0001, drive 0101 -> next cycle code_valid=0, onehot_out=0, idx_out holds 1, step_err=1 for one cycle, fault=1, synced=0.
4. In TRACK at 0001, drive 0111 (skips index 2) -> step_err pulse, fault=1, code_valid=1, idx_out=3. With JCM_AUTO_RESYNC_EN, continue a clean sequence for 8 good steps -> synced=1, fault=0. Without the macro, fault stays 1.
5. After reset, drive 0110 then 0010 -> stays in SEEK, synced=0, fault=0, step_err=0. Then drive 1100 -> synced=1, idx_out=6.
6. Mid-sequence with wrap_cnt=3, assert reset with en=1 -> next cycle all outputs 0 and state SEEK. After deassertion, the first legal sample, e.g. 1000, re-syncs with idx_out=7.
